// File: rtl/app_feeder_pkg.sv
// Shared types and constants for the application stream feeder.
package app_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_R,
    HDR_L,
    WAIT,
    STREAM,
    DONE,
    ERROR
  } feeder_state_e;

  localparam int unsigned DESC_HDR_WORDS  = 2;
  localparam logic [31:0] END_OF_LIST_LEN = 32'h0;

endpackage

// File: rtl/feeder_skid_fifo.sv
// Small synchronous output FIFO; push and pop in one cycle keep occupancy unchanged.
module feeder_skid_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/app_stream_feeder.sv
// Walks a descriptor list in word memory and streams each payload at its release cycle.
// Optional APP_STREAM_FEEDER_STATS_EN adds stall/wait cycle counters.
module app_stream_feeder
  import app_feeder_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR     = 24'h000000,
  parameter int unsigned MAX_APP_WORDS = 4096,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        mem_en_o,
  output logic [23:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        tx_o,
  input  logic        credit_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] app_count_o
`ifdef APP_STREAM_FEEDER_STATS_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] wait_cycles_o
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_APP_WORDS + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  feeder_state_e state_q, state_d;
  logic [23:0]      addr_q;
  logic [31:0]      time_q, rel_q;
  logic [LEN_W-1:0] len_q, rd_cnt_q, pop_cnt_q;
  logic             rd_pend_q, l_pend_q;
  logic [15:0]      app_cnt_q;

  logic             fifo_empty, fifo_full, pop, rd_req, last_pop, start_ok;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occ_eff;
  logic [31:0]      fifo_head;

  assign start_ok = start_i && !busy_o;
  assign pop      = !fifo_empty && credit_i;
  assign last_pop = pop && (state_q == STREAM) && ((pop_cnt_q + LEN_ONE) == len_q);
  // Occupancy after this cycle's pop plus the read still in flight must leave a free slot.
  assign occ_eff  = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q} - {{CW{1'b0}}, pop};
  assign rd_req   = (state_q == STREAM) && (rd_cnt_q < len_q) && (!fifo_full || pop)
                    && (occ_eff < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_i) state_d = HDR_R;
      HDR_R:             state_d = HDR_L;
      HDR_L: begin
        if (l_pend_q) begin
          if (mem_data_i == END_OF_LIST_LEN)          state_d = DONE;
          else if (mem_data_i > 32'(MAX_APP_WORDS))   state_d = ERROR;
          else                                        state_d = WAIT;
        end
      end
      WAIT:              if (time_q >= rel_q) state_d = STREAM;
      STREAM:            if (last_pop) state_d = HDR_R;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o = (state_q == HDR_R) || ((state_q == HDR_L) && !l_pend_q) || rd_req;
    busy_o   = (state_q == HDR_R) || (state_q == HDR_L) || (state_q == WAIT) || (state_q == STREAM);
    done_o   = (state_q == DONE);
    error_o  = (state_q == ERROR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= BASE_ADDR;
      time_q    <= '0;
      rel_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      pop_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      l_pend_q  <= 1'b0;
      app_cnt_q <= '0;
    end else if (start_ok) begin
      addr_q    <= BASE_ADDR;
      time_q    <= '0;
      rd_pend_q <= 1'b0;
      l_pend_q  <= 1'b0;
      app_cnt_q <= '0;
    end else begin
      if (busy_o)   time_q <= time_q + 32'd1;
      if (mem_en_o) addr_q <= addr_q + 24'd1;
      rd_pend_q <= rd_req;
      if (state_q == HDR_L) begin
        // First HDR_L cycle sees word0, second sees word1.
        if (!l_pend_q) begin
          rel_q    <= mem_data_i;
          l_pend_q <= 1'b1;
        end else begin
          l_pend_q  <= 1'b0;
          len_q     <= mem_data_i[LEN_W-1:0];
          rd_cnt_q  <= '0;
          pop_cnt_q <= '0;
        end
      end
      if (rd_req) rd_cnt_q <= rd_cnt_q + LEN_ONE;
      if (pop && (state_q == STREAM)) pop_cnt_q <= pop_cnt_q + LEN_ONE;
      if (last_pop && (app_cnt_q != 16'hFFFF)) app_cnt_q <= app_cnt_q + 16'd1;
    end
  end

  feeder_skid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rd_pend_q),
    .pop_i   (pop),
    .data_i  (mem_data_i),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign tx_o        = !fifo_empty;
  assign data_o      = fifo_empty ? 32'h0 : fifo_head;
  assign mem_addr_o  = addr_q;
  assign app_count_o = app_cnt_q;

`ifdef APP_STREAM_FEEDER_STATS_EN
  logic [31:0] stall_q, wait_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      if (tx_o && !credit_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if ((state_q == WAIT) && (wait_q != '1))  wait_q  <= wait_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign wait_cycles_o  = wait_q;
`endif

endmodule

// File: tb/tb_app_stream_feeder.sv
// Self-checking bench for app_stream_feeder against a descriptor-list reference model.
module tb_app_stream_feeder;

  localparam int MAXW = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        credit_i = 1'b0;
  logic        mem_en;
  logic [23:0] mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        tx_o, busy_o, done_o, error_o;
  logic [31:0] data_o;
  logic [15:0] app_count;
`ifdef APP_STREAM_FEEDER_STATS_EN
  logic [31:0] stall_cyc, wait_cyc;
`endif

  app_stream_feeder #(.BASE_ADDR(24'h000000), .MAX_APP_WORDS(MAXW), .FIFO_DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start_i),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_data_i  (mem_data),
    .tx_o        (tx_o),
    .credit_i    (credit_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .app_count_o (app_count)
`ifdef APP_STREAM_FEEDER_STATS_EN
    ,
    .stall_cycles_o (stall_cyc),
    .wait_cycles_o  (wait_cyc)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr[12:0]];

  int cmode = 0;
  always @(posedge clk) begin
    #1;
    case (cmode)
      0:       credit_i = 1'b1;
      1:       credit_i = ~credit_i;
      default: credit_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Observed transfers, each tagged with the cycle index relative to the accepted start.
  int          tnow = 0;
  logic [31:0] got_w[$];
  int          got_t[$];
  int          stall_obs = 0;
  int          memen_cnt = 0;

  always @(posedge clk) begin
    if (start_i && !busy_o) tnow <= 0;
    else                    tnow <= tnow + 1;
  end

  always @(negedge clk) begin
    if (tx_o && credit_i) begin
      got_w.push_back(data_o);
      got_t.push_back(tnow);
    end
    if (tx_o && !credit_i) stall_obs++;
    if (mem_en) memen_cnt++;
  end

  typedef struct { int r; int l; } app_t;
  app_t        apps[$];
  logic [31:0] exp_w[$];
  int          exp_rel[$];
  int          exp_apps;
  bit          exp_done, exp_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Lays the descriptor list into memory and derives the expected stream from it.
  task automatic build();
    int a;
    logic [31:0] w;
    a = 0;
    exp_w.delete(); exp_rel.delete();
    exp_apps = 0; exp_done = 0; exp_err = 0;
    for (int k = 0; k < apps.size(); k++) begin
      mem[a[12:0]] = apps[k].r; a++;
      mem[a[12:0]] = apps[k].l; a++;
      if (apps[k].l == 0) begin exp_done = 1; break; end
      if (apps[k].l > MAXW) begin exp_err = 1; break; end
      for (int i = 0; i < apps[k].l; i++) begin
        w = $urandom;
        mem[a[12:0]] = w; a++;
        exp_w.push_back(w);
        exp_rel.push_back(apps[k].r);
      end
      exp_apps++;
    end
    if (!exp_done && !exp_err) begin
      mem[a[12:0]] = $urandom; a++;
      mem[a[12:0]] = 32'h0;
      exp_done = 1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy_o) begin to = 0; break; end
    end
  endtask

  task automatic run_list(input int budget, output bit to, output int base);
    base = got_w.size();
    pulse_start();
    wait_idle(budget, to);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (tx_o !== 1'b0)    begin n_bad++; $display("FAIL reset_tx got %b want 0", tx_o); end
    n_cmp++; if (mem_en !== 1'b0)  begin n_bad++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    n_cmp++; if (mem_addr !== 24'h0) begin n_bad++; $display("FAIL reset_addr got %h want 000000", mem_addr); end
    n_cmp++; if ({busy_o, done_o, error_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy_o, done_o, error_o}); end
    n_cmp++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", data_o); end
    n_cmp++; if (app_count !== 16'h0) begin n_bad++; $display("FAIL reset_app_count got %0d want 0", app_count); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    bit to; int b;
    apps.delete(); apps.push_back('{0, 3});
    cmode = 0; build(); run_list(500, to, b);
    n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout busy still %b want 0", busy_o); end
    n_cmp++; if (got_w.size() - b != 3) begin n_bad++; $display("FAIL basic_count got %0d want 3", got_w.size() - b); end
    for (int i = 0; i < 3 && b + i < got_w.size(); i++) begin
      n_cmp++; if (got_w[b+i] !== exp_w[i]) begin n_bad++; $display("FAIL basic_word%0d got %h want %h", i, got_w[b+i], exp_w[i]); end
    end
    if (got_w.size() - b >= 3) begin
      n_cmp++; if (got_t[b+2] - got_t[b] != 2) begin n_bad++; $display("FAIL basic_consecutive got span %0d want 2", got_t[b+2] - got_t[b]); end
    end
    n_cmp++; if (app_count !== 16'd1) begin n_bad++; $display("FAIL basic_app_count got %0d want 1", app_count); end
    n_cmp++; if ({done_o, error_o} !== 2'b10) begin n_bad++; $display("FAIL basic_done got %b want 10", {done_o, error_o}); end
  endtask

  task automatic test_release();
    bit to; int b;
    apps.delete(); apps.push_back('{100, 3});
    cmode = 0; build(); run_list(800, to, b);
    n_cmp++; if (to) begin n_bad++; $display("FAIL release_timeout busy still %b want 0", busy_o); end
    n_cmp++; if (got_w.size() - b != 3) begin n_bad++; $display("FAIL release_count got %0d want 3", got_w.size() - b); end
    if (got_w.size() > b) begin
      n_cmp++; if (got_t[b] < 100) begin n_bad++; $display("FAIL release_first_tx got t=%0d want >=100", got_t[b]); end
    end
`ifdef APP_STREAM_FEEDER_STATS_EN
    n_cmp++; if (wait_cyc < 98 || wait_cyc > 101) begin n_bad++; $display("FAIL release_wait_cycles got %0d want 98..101", wait_cyc); end
`endif
  endtask

  task automatic test_backpressure();
    bit to; int b, s0, n;
    apps.delete(); apps.push_back('{0, 8});
    cmode = 1; build(); s0 = stall_obs; run_list(800, to, b);
    n_cmp++; if (to) begin n_bad++; $display("FAIL toggle_timeout busy still %b want 0", busy_o); end
    n_cmp++; if (got_w.size() - b != 8) begin n_bad++; $display("FAIL toggle_count got %0d want 8", got_w.size() - b); end
    for (int i = 0; i < 8 && b + i < got_w.size(); i++) begin
      n_cmp++; if (got_w[b+i] !== exp_w[i]) begin n_bad++; $display("FAIL toggle_word%0d got %h want %h", i, got_w[b+i], exp_w[i]); end
    end
`ifdef APP_STREAM_FEEDER_STATS_EN
    n_cmp++; if (stall_cyc !== 32'(stall_obs - s0)) begin n_bad++; $display("FAIL toggle_stall_cycles got %0d want %0d", stall_cyc, stall_obs - s0); end
`endif
    for (int it = 0; it < 4; it++) begin
      apps.delete();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) apps.push_back('{int'($urandom_range(0, 60)), int'($urandom_range(1, 12))});
      cmode = 2; build(); run_list(3000, to, b);
      n_cmp++; if (to) begin n_bad++; $display("FAIL rand%0d_timeout busy still %b want 0", it, busy_o); end
      n_cmp++; if (got_w.size() - b != exp_w.size()) begin n_bad++; $display("FAIL rand%0d_count got %0d want %0d", it, got_w.size() - b, exp_w.size()); end
      for (int i = 0; i < exp_w.size() && b + i < got_w.size(); i++) begin
        n_cmp++; if (got_w[b+i] !== exp_w[i]) begin n_bad++; $display("FAIL rand%0d_word%0d got %h want %h", it, i, got_w[b+i], exp_w[i]); end
        n_cmp++; if (got_t[b+i] < exp_rel[i]) begin n_bad++; $display("FAIL rand%0d_release%0d got t=%0d want >=%0d", it, i, got_t[b+i], exp_rel[i]); end
      end
      n_cmp++; if (app_count !== 16'(exp_apps)) begin n_bad++; $display("FAIL rand%0d_app_count got %0d want %0d", it, app_count, exp_apps); end
      n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL rand%0d_done got %b want 1", it, done_o); end
    end
  endtask

  task automatic test_error();
    bit to; int b, m0;
    apps.delete(); apps.push_back('{5, MAXW + 1});
    cmode = 0; build(); run_list(500, to, b);
    n_cmp++; if (to) begin n_bad++; $display("FAIL error_timeout busy still %b want 0", busy_o); end
    n_cmp++; if ({busy_o, done_o, error_o} !== 3'b001) begin n_bad++; $display("FAIL error_flags got %b want 001", {busy_o, done_o, error_o}); end
    m0 = memen_cnt;
    repeat (20) @(negedge clk);
    n_cmp++; if (memen_cnt != m0) begin n_bad++; $display("FAIL error_reads_stop got %0d extra reads want 0", memen_cnt - m0); end
    n_cmp++; if (got_w.size() != b || tx_o !== 1'b0) begin n_bad++; $display("FAIL error_no_tx got %0d words want 0", got_w.size() - b); end
    n_cmp++; if (app_count !== 16'd0) begin n_bad++; $display("FAIL error_app_count got %0d want 0", app_count); end
  endtask

  task automatic test_max_len();
    bit to; int b, bad;
    apps.delete(); apps.push_back('{0, MAXW});
    cmode = 0; build(); run_list(6000, to, b);
    bad = 0;
    for (int i = 0; i < MAXW && b + i < got_w.size(); i++) if (got_w[b+i] !== exp_w[i]) bad++;
    n_cmp++; if (to) begin n_bad++; $display("FAIL maxlen_timeout busy still %b want 0", busy_o); end
    n_cmp++; if (got_w.size() - b != MAXW || bad != 0) begin n_bad++; $display("FAIL maxlen_stream got %0d words %0d wrong want %0d words 0 wrong", got_w.size() - b, bad, MAXW); end
    n_cmp++; if ({app_count, error_o} !== {16'd1, 1'b0}) begin n_bad++; $display("FAIL maxlen_result got count %0d err %b want 1 0", app_count, error_o); end
  endtask

  task automatic test_reset_mid();
    bit to; int b, c;
    apps.delete(); apps.push_back('{0, 5});
    cmode = 0; build();
    b = got_w.size();
    pulse_start();
    to = 1;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (got_w.size() - b >= 2) begin to = 0; break; end
    end
    n_cmp++; if (to) begin n_bad++; $display("FAIL rstmid_reach got %0d words want 2", got_w.size() - b); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({tx_o, mem_en, busy_o, done_o, error_o} !== 5'b0) begin n_bad++; $display("FAIL rstmid_outputs got %b want 00000", {tx_o, mem_en, busy_o, done_o, error_o}); end
    n_cmp++; if (data_o !== 32'h0 || app_count !== 16'h0 || mem_addr !== 24'h0) begin n_bad++; $display("FAIL rstmid_values got data %h count %0d addr %h want 0 0 0", data_o, app_count, mem_addr); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_list(500, to, b);
    n_cmp++; if (got_w.size() - b != 5) begin n_bad++; $display("FAIL rstmid_replay_count got %0d want 5", got_w.size() - b); end
    for (int i = 0; i < 5 && b + i < got_w.size(); i++) begin
      n_cmp++; if (got_w[b+i] !== exp_w[i]) begin n_bad++; $display("FAIL rstmid_replay_word%0d got %h want %h", i, got_w[b+i], exp_w[i]); end
    end
    n_cmp++; if (app_count !== 16'd1 || done_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_replay_done got count %0d done %b want 1 1", app_count, done_o); end
  endtask

  task automatic test_back_to_back();
    bit to; int b;
    apps.delete(); apps.push_back('{0, 2}); apps.push_back('{5, 1});
    cmode = 0; build();
    b = got_w.size();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_idle(500, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_timeout busy still %b want 0", busy_o); end
    n_cmp++; if (got_w.size() - b != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", got_w.size() - b); end
    for (int i = 0; i < 3 && b + i < got_w.size(); i++) begin
      n_cmp++; if (got_w[b+i] !== exp_w[i]) begin n_bad++; $display("FAIL b2b_word%0d got %h want %h", i, got_w[b+i], exp_w[i]); end
    end
    if (got_w.size() - b >= 3) begin
      n_cmp++; if (got_t[b+2] < 5) begin n_bad++; $display("FAIL b2b_release got t=%0d want >=5", got_t[b+2]); end
    end
    n_cmp++; if (app_count !== 16'd2 || done_o !== 1'b1) begin n_bad++; $display("FAIL b2b_result got count %0d done %b want 2 1", app_count, done_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_release();
    test_backpressure();
    test_error();
    test_max_len();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
